// File: rtl/multex_phase_decoder.sv
// multex_phase_decoder: recovers the 2-bit select code (A,B) of the three-phase multiplexer
// by correlating the observed line against each reference phase over a window of WIN samples.
// Latency: valid pulses WIN+1 clk edges after the edge that accepts start; start while busy is ignored.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   q_in   - multiplexed line under observation (may be asynchronous)
//   ph     - reference phases; ph[i] is the phase driven when channel i is selected (may be asynchronous)
//   start  - request one decode window; only honoured in IDLE
//   a_out  - decoded A bit (held between valid pulses)
//   b_out  - decoded B bit (held between valid pulses)
//   valid  - one-cycle pulse marking an update of a_out/b_out/err
//   err    - decision ambiguous (tie) or no phase reached THR
//   busy   - window or decision in progress
//
// Optional build macro: MULTEX_PHASE_DECODER_CONTINUOUS_EN
//   When defined, windows run back to back from the first edge after reset;
//   start is ignored and busy stays high.

module multex_phase_decoder #(
  parameter int WIN = 16,  // samples per window, 2..255
  parameter int THR = 14   // agreeing samples needed for a candidate, WIN/2 < THR <= WIN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       q_in,
  input  logic [2:0] ph,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int CW = $clog2(WIN + 1);
  localparam logic [CW-1:0] WIN_C  = CW'(WIN);
  localparam logic [CW-1:0] LAST_C = CW'(WIN - 1);
  localparam logic [CW-1:0] THR_C  = CW'(THR);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    DECIDE = 2'd2
  } state_t;

  state_t state;

  // Two-flop synchronisers; q and the phases share the same depth so their
  // relative alignment is preserved when compared.
  logic       q_s1, q_s2;
  logic [2:0] ph_s1, ph_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s1  <= 1'b0;
      q_s2  <= 1'b0;
      ph_s1 <= 3'b000;
      ph_s2 <= 3'b000;
    end else begin
      q_s1  <= q_in;
      q_s2  <= q_s1;
      ph_s1 <= ph;
      ph_s2 <= ph_s1;
    end
  end

  // Window statistics
  logic [CW-1:0] hi_cnt;
  logic [CW-1:0] match [3];
  logic [CW-1:0] smp_cnt;   // samples already taken in the current window

  // Candidate phases: enough samples agreeing with the line.
  logic [2:0] cand;
  always_comb begin
    cand = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cand[i] = (match[i] >= THR_C);
    end
  end

  // Decision table. A silent line wins over everything else, then exactly
  // one candidate selects its code; no candidate or a tie is an error.
  logic dec_a, dec_b, dec_err;
  always_comb begin
    dec_a   = 1'b0;
    dec_b   = 1'b0;
    dec_err = 1'b0;
    if (hi_cnt == '0) begin
      dec_err = 1'b0;
    end else begin
      case (cand)
        3'b001:  begin dec_a = 1'b1; dec_b = 1'b0; end
        3'b010:  begin dec_a = 1'b0; dec_b = 1'b1; end
        3'b100:  begin dec_a = 1'b1; dec_b = 1'b1; end
        default: dec_err = 1'b1;
      endcase
    end
  end

  // Main control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hi_cnt  <= '0;
      smp_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        match[i] <= '0;
      end
      a_out   <= 1'b0;
      b_out   <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MULTEX_PHASE_DECODER_CONTINUOUS_EN
          // Free-running: the first window opens on the first edge after reset.
          state   <= ACQ;
          busy    <= 1'b1;
          hi_cnt  <= '0;
          smp_cnt <= '0;
          for (int i = 0; i < 3; i++) begin
            match[i] <= '0;
          end
`else
          if (start) begin
            state   <= ACQ;
            busy    <= 1'b1;
            hi_cnt  <= '0;
            smp_cnt <= '0;
            for (int i = 0; i < 3; i++) begin
              match[i] <= '0;
            end
          end
`endif
        end

        ACQ: begin
          // Counters saturate at WIN; with exactly WIN samples they never
          // need to, but saturation keeps them bounded regardless.
          if (q_s2 && (hi_cnt != WIN_C)) begin
            hi_cnt <= hi_cnt + ONE_C;
          end
          for (int i = 0; i < 3; i++) begin
            if ((q_s2 == ph_s2[i]) && (match[i] != WIN_C)) begin
              match[i] <= match[i] + ONE_C;
            end
          end
          smp_cnt <= smp_cnt + ONE_C;
          // This edge takes the WIN-th sample; decide on the next one.
          if (smp_cnt == LAST_C) begin
            state <= DECIDE;
          end
        end

        DECIDE: begin
          a_out <= dec_a;
          b_out <= dec_b;
          err   <= dec_err;
          valid <= 1'b1;
`ifdef MULTEX_PHASE_DECODER_CONTINUOUS_EN
          // Back-to-back windows: this edge plays the role of the start edge.
          state   <= ACQ;
          hi_cnt  <= '0;
          smp_cnt <= '0;
          for (int i = 0; i < 3; i++) begin
            match[i] <= '0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multex_phase_decoder.sv
module tb_multex_phase_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       q_in;
  logic [2:0] ph;
  logic       start;
  logic       a_out, b_out, valid, err, busy;

  int total  = 0;
  int passed = 0;

  multex_phase_decoder #(.WIN(16), .THR(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q_in  (q_in),
    .ph    (ph),
    .start (start),
    .a_out (a_out),
    .b_out (b_out),
    .valid (valid),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Drives one window. Inputs change at negedges; start is seen at the edge
  // after drive step c=2 (edge k). Observing at negedge c shows edge c-1, so
  // latency from edge k is c-3. Samples taken in the window reflect drive
  // steps 1..16. ph patterns: ph0=1100, ph1=1010, ph2=1001 (repeating).
  task automatic run_win(input int qsel, input int ninv, input bit tie, input int start2,
                         output int nval, output int lat, output logic a, output logic b,
                         output logic e, output logic bsy_k);
    logic [2:0] p;
    logic       q;
    int         m;
    nval = 0; lat = -1; a = 1'bx; b = 1'bx; e = 1'bx; bsy_k = 1'bx;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (valid) begin
        nval++;
        if (nval == 1) begin
          lat = c - 3; a = a_out; b = b_out; e = err;
        end
      end
      if (c == 3) bsy_k = busy;
      m = c % 4;
      p[0] = (m < 2);
      p[1] = tie ? p[0] : (m % 2 == 0);
      p[2] = (m == 0) || (m == 3);
      q = (qsel == 3) ? 1'b0 : p[qsel];
      if ((ninv >= 1 && c == 5) || (ninv >= 2 && c == 9) || (ninv >= 3 && c == 13)) q = ~q;
      ph    = p;
      q_in  = q;
      start = (c == 2) || (c == start2);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  int   nv, lt;
  logic ra, rb, re, rbk;

  initial begin
    rst_n = 1'b0; start = 1'b0; q_in = 1'b0; ph = 3'b000;
    #12;
    chk("rst_a",     a_out, 0);
    chk("rst_b",     b_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err",   err,   0);
    chk("rst_busy",  busy,  0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy",  busy,  0);
    chk("idle_valid", valid, 0);

    // q = ph0 -> code 10
    run_win(0, 0, 1'b0, -1, nv, lt, ra, rb, re, rbk);
    chk("p0_busy_k", rbk, 1);
    chk("p0_nval", nv, 1);
    chk("p0_lat",  lt, 17);
    chk("p0_a", ra, 1); chk("p0_b", rb, 0); chk("p0_err", re, 0);
    chk("p0_busy_after", busy, 0);

    // q held 0 -> silent 00
    run_win(3, 0, 1'b0, -1, nv, lt, ra, rb, re, rbk);
    chk("z_nval", nv, 1); chk("z_lat", lt, 17);
    chk("z_a", ra, 0); chk("z_b", rb, 0); chk("z_err", re, 0);

    // q = ph2 with 2 inverted -> 14 matches, code 11
    run_win(2, 2, 1'b0, -1, nv, lt, ra, rb, re, rbk);
    chk("p2i2_nval", nv, 1);
    chk("p2i2_a", ra, 1); chk("p2i2_b", rb, 1); chk("p2i2_err", re, 0);

    // q = ph2 with 3 inverted -> 13 matches, below threshold
    run_win(2, 3, 1'b0, -1, nv, lt, ra, rb, re, rbk);
    chk("p2i3_nval", nv, 1);
    chk("p2i3_a", ra, 0); chk("p2i3_b", rb, 0); chk("p2i3_err", re, 1);

    // ph0 == ph1 -> tie
    run_win(0, 0, 1'b1, -1, nv, lt, ra, rb, re, rbk);
    chk("tie_nval", nv, 1);
    chk("tie_a", ra, 0); chk("tie_b", rb, 0); chk("tie_err", re, 1);

    // q = ph0 with an extra start inside ACQ -> ignored, single window
    run_win(0, 0, 1'b0, 8, nv, lt, ra, rb, re, rbk);
    chk("busy_start_nval", nv, 1);
    chk("bs_lat", lt, 17);
    chk("bs_a", ra, 1); chk("bs_b", rb, 0); chk("bs_err", re, 0);
    repeat (5) @(negedge clk);
    chk("hold_a", a_out, 1); chk("hold_b", b_out, 0); chk("hold_err", err, 0);
    chk("hold_busy", busy, 0);

    // Reset 8 cycles into ACQ aborts the window
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a",     a_out, 0);
    chk("mid_rst_b",     b_out, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_err",   err,   0);
    chk("mid_rst_busy",  busy,  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort_nval", nv, 0);
    chk("abort_busy", busy, 0);

    // Recovery after abort: q = ph1 -> code 01
    run_win(1, 0, 1'b0, -1, nv, lt, ra, rb, re, rbk);
    chk("p1_nval", nv, 1); chk("p1_lat", lt, 17);
    chk("p1_a", ra, 0); chk("p1_b", rb, 1); chk("p1_err", re, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multex_phase_decoder.md
Name: multex_phase_decoder

Overview:
- Receive-side counterpart of the three-phase channel multiplexer.
- Observes the single multiplexed line together with the three reference phase signals over a fixed sampling window.
- Recovers the 2-bit select code (A,B) that produced the line: 10 = phase 0, 01 = phase 1, 11 = phase 2, 00 = silent.
- Sits at the consumer end of the link and reports the decoded code with a valid pulse and an error flag.

Parameters:
- WIN, 16, samples per decision window; legal range 2..255.
- THR, 14, minimum agreeing samples for a phase to be a candidate; must satisfy WIN/2 < THR <= WIN.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- q_in  input  1  multiplexed line under observation; may be asynchronous to clk.
- ph  input  3  reference phase signals; ph[i] is the phase driven when channel i is selected; may be asynchronous to clk.
- start  input  1  request one decode window; acted on only in IDLE.
- a_out  output  1  decoded A bit.
- b_out  output  1  decoded B bit.
- valid  output  1  one-cycle pulse; a_out, b_out and err are updated on this cycle.
- err  output  1  decision ambiguous or below threshold.
- busy  output  1  high while a window or decision is in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State returns to IDLE and all counters clear.
  - a_out, b_out, valid, err and busy all go to 0.
  - Synchroniser flops clear to 0.
- Input synchronisation:
  - q_in and ph[2:0] each pass through a 2-flop synchroniser.
  - Every sample the decoder uses reflects the inputs as they were 2 clk edges earlier.
- Counters:
  - hi_cnt counts samples with synced q = 1.
  - match[i], i = 0..2, counts samples with synced q == synced ph[i].
  - All counters are $clog2(WIN+1) bits wide and saturate at WIN; they cannot exceed WIN by construction.
- FSM states: IDLE, ACQ, DECIDE.
  - IDLE: busy = 0. If start = 1 at edge k, clear all counters and go to ACQ; busy = 1 from edge k.
  - ACQ: one sample per cycle, taken at edges k+1 .. k+WIN (exactly WIN samples). At edge k+WIN go to DECIDE.
  - DECIDE: at edge k+WIN+1 register the result, assert valid for exactly that one cycle, and return to IDLE; busy falls at the same edge.
  - Latency from start to valid is WIN+1 edges.
- Decision rules, evaluated in this order:
  - hi_cnt == 0: code 00, err = 0.
  - Exactly one i with match[i] >= THR: err = 0 and the code is set by that phase: i = 0 gives a_out = 1, b_out = 0; i = 1 gives 0,1; i = 2 gives 1,1.
  - Zero candidates, or two or more (ties): code 00, err = 1.
- Hold behaviour: a_out, b_out and err hold their value between valid pulses and change only on a valid cycle.
- start while busy (ACQ or DECIDE) is ignored; requests are not queued.
- start held high across the DECIDE -> IDLE edge starts a new window on the next edge.
- Reset asserted mid-window aborts the window; no valid pulse is issued. After release the block waits for a new start.

Optional Feature:
- Macro: MULTEX_PHASE_DECODER_CONTINUOUS_EN.
- Defined:
  - After DECIDE, go straight to ACQ with counters cleared; no IDLE visit and start is not required.
  - The first window begins on the first edge after rst_n deasserts.
  - valid pulses every WIN+1 cycles; busy stays 1 from that first edge; start is ignored.
- Not defined: one-shot operation exactly as described under Behaviour.

Test Plan:
- WIN=16, THR=14, ph = {1100 repeating, 1010 repeating, 1001 repeating}, q_in = ph[0] (incl. sync delay), pulse start -> valid 17 cycles after start; a_out=1, b_out=0, err=0.
- q_in held 0, pulse start -> valid after 17 cycles; a_out=0, b_out=0, err=0.
- q_in = ph[2] with 2 samples inverted (14 matches) -> code 11, err=0; repeat with 3 inverted (13 matches) -> code 00, err=1.
- ph[0] == ph[1] (identical patterns), q_in = ph[0] -> tie between two candidates -> code 00, err=1.
- Drop rst_n 8 cycles into ACQ -> all outputs 0 immediately, no valid pulse; a start pulse during busy in a later window -> no extra window started.
- With MULTEX_PHASE_DECODER_CONTINUOUS_EN, q_in = ph[1] -> valid pulses every 17 cycles with code 01, no start needed; switching q_in to ph[0] mid-run gives code 10 from the first fully new window.
